// File: rtl/reg_pkg.sv
// Shared constants and the {sel,data} entry layout for the register load queue.
`timescale 1ns/1ps
package reg_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int SEL_W_DEF  = 10;

    typedef struct packed {
        logic [SEL_W_DEF-1:0]  sel;
        logic [DATA_W_DEF-1:0] data;
    } reg_entry_t;

endpackage

// File: rtl/reg_load_queue_mem.sv
// Queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
`timescale 1ns/1ps
module reg_load_queue_mem #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 30,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    // Contents are never reset; the owner's count decides which slots are live.
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_load_queue.sv
// FIFO of register writes feeding a one-cycle load strobe to a general-purpose register.
// Optional build macro REG_LOAD_QUEUE_BYPASS_EN: a write into an empty, unstalled queue skips storage.
`timescale 1ns/1ps
module reg_load_queue
    import reg_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              stall,
    output logic              load,
    output logic [DATA_W-1:0] i,
    output logic [SEL_W-1:0]  j,
    output logic              overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = SEL_W + DATA_W;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          store;

    // Handshake: a write transfers on a rising edge where in_valid and in_ready are
    // both high; in_ready depends only on count, so a same-cycle pop never raises it.
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (count != '0) & ~stall;
    assign wr_entry = '{sel: in_sel, data: in_data};

`ifdef REG_LOAD_QUEUE_BYPASS_EN
    assign bypass = push & (count == '0) & ~stall;
`else
    assign bypass = 1'b0;
`endif

    assign store = push & ~bypass;

    reg_load_queue_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            load     <= 1'b0;
            i        <= '0;
            j        <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
            if (store) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            load <= pop | bypass;
            if (bypass) begin
                j <= wr_entry.sel;
                i <= wr_entry.data;
            end else if (pop) begin
                j <= rd_entry.sel;
                i <= rd_entry.data;
            end
            if (in_valid & ~in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_load_queue.sv
// Directed bench for reg_load_queue with hand-computed expectations and a small ordering queue.
`timescale 1ns/1ps
module tb_reg_load_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic [9:0]  in_sel;
    logic        stall;
    logic        load;
    logic [19:0] i;
    logic [9:0]  j;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [29:0] exp_q[$];

`ifdef REG_LOAD_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_load_queue dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .stall    (stall),
        .load     (load),
        .i        (i),
        .j        (j),
        .overflow (overflow)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic [9:0] s, input logic [19:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    // waits (bounded) for the next load and checks it carries the expected entry
    task automatic expect_load(input string tag, input logic [9:0] es, input logic [19:0] ed);
        int n;
        n = 0;
        while (load !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        check({tag, "_load"}, {31'd0, load}, 32'd1);
        check({tag, "_i"}, {12'd0, i}, {12'd0, ed});
        check({tag, "_j"}, {22'd0, j}, {22'd0, es});
    endtask

    // scoreboard: compare the observed load against the head of exp_q
    task automatic score(input string tag);
        logic [29:0] e;
        if (load === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_load"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_entry"}, {2'd0, j, i}, {2'd0, e});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        drive(1'b0, 10'h000, 20'h00000);

        // reset held 12.5 ns with no traffic
        #2;
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_i", {12'd0, i}, 32'd0);
        check("rst_j", {22'd0, j}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        #4;
        check("rst_edge_load", {31'd0, load}, 32'd0);
        check("rst_edge_in_ready", {31'd0, in_ready}, 32'd1);
        #6.5;
        reset = 1'b0;
        tick();
        check("post_rst_load", {31'd0, load}, 32'd0);
        check("post_rst_count", {28'd0, dut.count}, 32'd0);

        // single write into an empty queue
        drive(1'b1, 10'h001, 20'h00005);
        tick();
        drive(1'b0, 10'h000, 20'h00000);
        if (BYP) begin
            check("single_load_c1", {31'd0, load}, 32'd1);
        end else begin
            check("single_load_c1", {31'd0, load}, 32'd0);
            tick();
            check("single_load_c2", {31'd0, load}, 32'd1);
        end
        check("single_i", {12'd0, i}, 32'h00005);
        check("single_j", {22'd0, j}, 32'h001);
        tick();
        check("single_load_off", {31'd0, load}, 32'd0);
        check("single_i_held", {12'd0, i}, 32'h00005);
        check("single_j_held", {22'd0, j}, 32'h001);

        // fill while stalled, fifth write overflows and is discarded
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fill_ready_%0d", k), {31'd0, in_ready}, (k < 4) ? 32'd1 : 32'd0);
            drive(1'b1, 10'(k + 2), 20'(6 + k));
            tick();
            check($sformatf("fill_noload_%0d", k), {31'd0, load}, 32'd0);
        end
        drive(1'b0, 10'h000, 20'h00000);
        check("fill_count", {28'd0, dut.count}, 32'd4);
        check("fill_overflow", {31'd0, overflow}, 32'd1);
        stall = 1'b0;
        check("full_pop_no_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drain_load_%0d", k), {31'd0, load}, 32'd1);
            check($sformatf("drain_i_%0d", k), {12'd0, i}, 32'(6 + k));
            check($sformatf("drain_j_%0d", k), {22'd0, j}, 32'(k + 2));
        end
        tick();
        check("drain_done_load", {31'd0, load}, 32'd0);
        check("drain_done_i", {12'd0, i}, 32'h00009);
        check("drain_done_count", {28'd0, dut.count}, 32'd0);
        check("overflow_sticky", {31'd0, overflow}, 32'd1);

        // continuous push with stall low: pointers wrap past DEPTH
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 10'(12'h100 + k), 20'(20'hB + k));
            exp_q.push_back({10'(12'h100 + k), 20'(20'hB + k)});
            tick();
            check($sformatf("stream_load_%0d", k), {31'd0, load}, (BYP || k > 0) ? 32'd1 : 32'd0);
            check($sformatf("stream_count_%0d", k), {28'd0, dut.count}, BYP ? 32'd0 : 32'd1);
            score($sformatf("stream_%0d", k));
        end
        drive(1'b0, 10'h000, 20'h00000);
        for (int k = 0; k < 3; k++) begin
            tick();
            score($sformatf("stream_tail_%0d", k));
        end
        check("stream_all_loaded", 32'(exp_q.size()), 32'd0);
        check("stream_final_count", {28'd0, dut.count}, 32'd0);

        // reset pulsed mid-operation with three entries queued
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 10'(10'h030 + k), 20'(20'h30 + k));
            tick();
        end
        drive(1'b0, 10'h000, 20'h00000);
        check("pre_rst_count", {28'd0, dut.count}, 32'd3);
        reset = 1'b1;
        #1;
        check("midrst_load", {31'd0, load}, 32'd0);
        check("midrst_count", {28'd0, dut.count}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        tick();
        check("after_rst_no_load", {31'd0, load}, 32'd0);
        drive(1'b1, 10'h03C, 20'h0000C);
        tick();
        drive(1'b0, 10'h000, 20'h00000);
        expect_load("after_rst_first", 10'h03C, 20'h0000C);

        // simultaneous push and pop at count 2
        tick();
        stall = 1'b1;
        drive(1'b1, 10'h021, 20'h00021);
        tick();
        drive(1'b1, 10'h022, 20'h00022);
        tick();
        check("pp_pre_count", {28'd0, dut.count}, 32'd2);
        stall = 1'b0;
        drive(1'b1, 10'h023, 20'h00023);
        tick();
        drive(1'b0, 10'h000, 20'h00000);
        check("pp_count", {28'd0, dut.count}, 32'd2);
        check("pp_load", {31'd0, load}, 32'd1);
        check("pp_i_0", {12'd0, i}, 32'h00021);
        tick();
        check("pp_i_1", {12'd0, i}, 32'h00022);
        tick();
        check("pp_i_2", {12'd0, i}, 32'h00023);
        check("pp_j_2", {22'd0, j}, 32'h023);
        tick();
        check("pp_end_load", {31'd0, load}, 32'd0);
        check("pp_end_count", {28'd0, dut.count}, 32'd0);
        check("pp_overflow_clear", {31'd0, overflow}, 32'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // watchdog keeps the run bounded even if the sequence stalls
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
